// File: rtl/perf_mmio_unit_pkg.sv
// Shared types for the performance-counter MMIO window.
package perf_mmio_unit_pkg;

  typedef logic [3:0] perf_idx_t;

  typedef enum logic {PERF_IDLE, PERF_RESP} perf_state_t;

  localparam perf_idx_t PERF_IDX_OVF  = 4'hE;
  localparam perf_idx_t PERF_IDX_CTRL = 4'hF;

endpackage

// File: rtl/perf_ovf_detect.sv
// Per-counter sticky wrap detector: flags a FFFF->0000 transition that was not
// caused by our own clear pulse. Only built when PERF_OVERFLOW_EN is defined.
module perf_ovf_detect (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count,
  input  logic        clr,
  input  logic        w1c,
  output logic        ovf
);

  logic [15:0] prev;
  logic        clr_q;
  logic        wrap;

  // A wrap right after our clear pulse is the clear, not an overflow.
  assign wrap = (prev == 16'hFFFF) && (count == 16'h0000) && !clr_q;

  // Track last count and clear; sticky flag, set has priority over W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 16'h0000;
      clr_q <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      prev  <= count;
      clr_q <= clr;
      ovf   <= wrap | (ovf & ~w1c);
    end
  end

endmodule

// File: rtl/perf_mmio_unit.sv
// MMIO readout/control for pipeline event counters on the MEM-stage data port.
// 16-word window: idx<NUM_CNT counters, 14 overflow flags, 15 control.
// Optional feature: define PERF_OVERFLOW_EN for sticky wrap flags at idx 14.
module perf_mmio_unit
  import perf_mmio_unit_pkg::*;
#(
  parameter int          NUM_CNT   = 4,
  parameter logic [15:0] PERF_BASE = 16'hFFE0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               mem_address,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [15:0]               mem_wdata,
  input  logic [1:0]                mem_byte_enable,
  input  logic [NUM_CNT-1:0][15:0]  counts,
  output logic                      hit,
  output logic [15:0]               mem_rdata,
  output logic                      mem_resp,
  output logic [NUM_CNT-1:0]        cnt_clear
);

  perf_state_t              state, state_nxt;
  perf_idx_t                idx;
  logic                     accept, wr_act;
  logic                     freeze;
  logic [NUM_CNT-1:0][15:0] snap;
  logic [NUM_CNT-1:0]       ovf;
  logic [NUM_CNT-1:0]       clr_nxt;
  logic [15:0]              rd_val;
  logic                     unused_bits;

  assign hit      = (mem_read | mem_write) && (mem_address[15:5] == PERF_BASE[15:5]);
  assign idx      = mem_address[4:1];
  assign accept   = (state == PERF_IDLE) && hit;
  assign wr_act   = accept && mem_write && (mem_byte_enable != 2'b00);
  assign mem_resp = (state == PERF_RESP);

  assign unused_bits = ^{mem_address[0], mem_wdata[15:2]};

  // Read map for the addressed word.
  always_comb begin
    rd_val = 16'h0000;
    for (int i = 0; i < NUM_CNT; i++)
      if (idx == 4'(i)) rd_val = freeze ? snap[i] : counts[i];
    if (idx == PERF_IDX_CTRL) rd_val = {14'b0, freeze, 1'b0};
    if (idx == PERF_IDX_OVF)  rd_val = 16'(ovf);
  end

  // Clear intent for the write being accepted; pulses out during RESP.
  always_comb begin
    clr_nxt = '0;
    if (wr_act) begin
      for (int i = 0; i < NUM_CNT; i++)
        if (idx == 4'(i)) clr_nxt[i] = 1'b1;
      if (idx == PERF_IDX_CTRL && mem_wdata[1]) clr_nxt = '1;
    end
  end

  // Next state: one response cycle per accepted request.
  always_comb begin
    state_nxt = state;
    case (state)
      PERF_IDLE: if (hit) state_nxt = PERF_RESP;
      PERF_RESP: state_nxt = PERF_IDLE;
      default:   state_nxt = PERF_IDLE;
    endcase
  end

  // State, response data, clear pulses, freeze and snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PERF_IDLE;
      mem_rdata <= 16'h0000;
      cnt_clear <= '0;
      freeze    <= 1'b0;
      snap      <= '0;
    end else begin
      state     <= state_nxt;
      cnt_clear <= clr_nxt;
      if (accept && mem_read) mem_rdata <= rd_val;
      if (wr_act && idx == PERF_IDX_CTRL) begin
        freeze <= mem_wdata[0];
        // Snapshot only on the 0->1 edge; counts here are still pre-clear.
        if (mem_wdata[0] && !freeze) snap <= counts;
      end
    end
  end

`ifdef PERF_OVERFLOW_EN
  logic [NUM_CNT-1:0] w1c;
  assign w1c = (wr_act && idx == PERF_IDX_OVF) ? mem_wdata[NUM_CNT-1:0] : '0;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ovf
    perf_ovf_detect u_det (
      .clk   (clk),
      .reset (reset),
      .count (counts[g]),
      .clr   (cnt_clear[g]),
      .w1c   (w1c[g]),
      .ovf   (ovf[g])
    );
  end
`else
  assign ovf = '0;
`endif

endmodule
